// File: rtl/control_sequencer.sv
// Microcode sequencer for an 8-bit accumulator CPU.
// It holds the instruction register and the microstep counter (T0..T4).
// It decodes the current opcode, step and ALU flags into the bus control lines.
// Optional feature: define SEQ_SHORTCUT_EN so each instruction returns to T0
// right after its last active microstep instead of always running to T4.
module control_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] BUS_IN,
  input  logic       CF,
  input  logic       ZF,
  output logic       CO,
  output logic       MI,
  output logic       RO,
  output logic       II,
  output logic       CE,
  output logic       IO,
  output logic       AI,
  output logic       AO,
  output logic       BI,
  output logic       RI,
  output logic       OI,
  output logic       J,
  output logic       HLT,
  output logic       SU,
  output logic       EO_n,
  output logic       FI_n,
  output logic [3:0] IR_LOW,
  output logic [2:0] STEP
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [7:0] ir_reg, ir_next;
  step_t      step_reg, step_next;
  logic [3:0] opc;
  logic       halted;

  assign opc    = ir_reg[7:4];
  assign halted = (step_reg == T2) && (opc == OP_HLT);

`ifdef SEQ_SHORTCUT_EN
  // Last microstep that does useful work for a given opcode.
  function automatic step_t final_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA:                         final_step = T3;
      OP_ADD, OP_SUB:                         final_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
      OP_HLT:                                 final_step = T2;
      default:                                final_step = T1;
    endcase
  endfunction
`endif

  // State register: reset beats halt hold and the IR load.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ir_reg   <= 8'h00;
      step_reg <= T0;
    end else begin
      ir_reg   <= ir_next;
      step_reg <= step_next;
    end
  end

  // Next state: load IR at the end of T1, advance the step, freeze while halted.
  always_comb begin
    ir_next   = ir_reg;
    step_next = step_reg;
    if (!halted) begin
      if (step_reg == T1) begin
        ir_next = BUS_IN;
      end
`ifdef SEQ_SHORTCUT_EN
      // In T1 the instruction being fetched is still on the bus, not in IR.
      if ((step_reg == T4) ||
          (step_reg == ((step_reg == T1) ? final_step(BUS_IN[7:4]) : final_step(opc)))) begin
        step_next = T0;
      end else begin
        step_next = step_t'(step_reg + 3'd1);
      end
`else
      if (step_reg >= T4) begin
        step_next = T0;
      end else begin
        step_next = step_t'(step_reg + 3'd1);
      end
`endif
    end
  end

  // Control decode: fetch in T0/T1, opcode microcode in T2..T4.
  always_comb begin
    CO   = 1'b0;
    MI   = 1'b0;
    RO   = 1'b0;
    II   = 1'b0;
    CE   = 1'b0;
    IO   = 1'b0;
    AI   = 1'b0;
    AO   = 1'b0;
    BI   = 1'b0;
    RI   = 1'b0;
    OI   = 1'b0;
    J    = 1'b0;
    HLT  = 1'b0;
    SU   = 1'b0;
    EO_n = 1'b1;
    FI_n = 1'b1;
    case (step_reg)
      T0: begin
        CO = 1'b1;
        MI = 1'b1;
      end
      T1: begin
        RO = 1'b1;
        II = 1'b1;
        CE = 1'b1;
      end
      T2: begin
        case (opc)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            IO = 1'b1;
            MI = 1'b1;
          end
          OP_LDI: begin
            IO = 1'b1;
            AI = 1'b1;
          end
          OP_JMP: begin
            IO = 1'b1;
            J  = 1'b1;
          end
          // Flags are read live so a late flag change still steers the jump.
          OP_JC: begin
            IO = 1'b1;
            J  = CF;
          end
          OP_JZ: begin
            IO = 1'b1;
            J  = ZF;
          end
          OP_OUT: begin
            AO = 1'b1;
            OI = 1'b1;
          end
          OP_HLT: HLT = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (opc)
          OP_LDA: begin
            RO = 1'b1;
            AI = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            RO = 1'b1;
            BI = 1'b1;
          end
          OP_STA: begin
            AO = 1'b1;
            RI = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opc == OP_ADD || opc == OP_SUB) begin
          AI   = 1'b1;
          EO_n = 1'b0;
          FI_n = 1'b0;
          SU   = (opc == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign IR_LOW = ir_reg[3:0];
  assign STEP   = step_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// instruction streams compared cycle by cycle against a table-driven model.
module tb_control_sequencer;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] BUS_IN;
  logic       CF;
  logic       ZF;
  logic CO, MI, RO, II, CE, IO, AI, AO, BI, RI, OI, J, HLT, SU, EO_n, FI_n;
  logic [3:0] IR_LOW;
  logic [2:0] STEP;

  int checks = 0;
  int errors = 0;

  // Reference model state: instruction byte and current microstep number.
  logic [7:0] m_ir = 8'h00;
  int         m_step = 0;
  bit         m_valid = 1'b0;

`ifdef SEQ_SHORTCUT_EN
  int ldi_seq[4] = '{0, 1, 2, 0};
`else
  int ldi_seq[6] = '{0, 1, 2, 3, 4, 0};
`endif

  control_sequencer dut (
    .CLK(CLK), .CLR(CLR), .BUS_IN(BUS_IN), .CF(CF), .ZF(ZF),
    .CO(CO), .MI(MI), .RO(RO), .II(II), .CE(CE), .IO(IO), .AI(AI), .AO(AO),
    .BI(BI), .RI(RI), .OI(OI), .J(J), .HLT(HLT), .SU(SU),
    .EO_n(EO_n), .FI_n(FI_n), .IR_LOW(IR_LOW), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Number of cycles an instruction occupies, T0 included.
  function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_SHORTCUT_EN
    case (op)
      4'h1, 4'h4:                      return 4;
      4'h2, 4'h3:                      return 5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE,
      4'hF:                            return 3;
      default:                         return 2;
    endcase
`else
    return 5;
`endif
  endfunction

  // Expected control word from the instruction table.
  function automatic logic [22:0] model_out(input logic [7:0] ir, input int st,
                                            input logic cf, input logic zf);
    logic co, mi, ro, ii, ce, io, ai, ao, bi, ri, oi, j, hlt, su, eo_n, fi_n;
    {co, mi, ro, ii, ce, io, ai, ao, bi, ri, oi, j, hlt, su} = '0;
    eo_n = 1'b1;
    fi_n = 1'b1;
    if (st == 0) begin
      co = 1; mi = 1;
    end else if (st == 1) begin
      ro = 1; ii = 1; ce = 1;
    end else begin
      case ({ir[7:4], 4'(st)})
        {4'h1, 4'd2}, {4'h2, 4'd2}, {4'h3, 4'd2}, {4'h4, 4'd2}: begin io = 1; mi = 1; end
        {4'h1, 4'd3}: begin ro = 1; ai = 1; end
        {4'h2, 4'd3}, {4'h3, 4'd3}: begin ro = 1; bi = 1; end
        {4'h2, 4'd4}: begin ai = 1; eo_n = 0; fi_n = 0; end
        {4'h3, 4'd4}: begin ai = 1; eo_n = 0; fi_n = 0; su = 1; end
        {4'h4, 4'd3}: begin ao = 1; ri = 1; end
        {4'h5, 4'd2}: begin io = 1; ai = 1; end
        {4'h6, 4'd2}: begin io = 1; j = 1; end
        {4'h7, 4'd2}: begin io = 1; j = cf; end
        {4'h8, 4'd2}: begin io = 1; j = zf; end
        {4'hE, 4'd2}: begin ao = 1; oi = 1; end
        {4'hF, 4'd2}: hlt = 1;
        default: ;
      endcase
    end
    return {co, mi, ro, ii, ce, io, ai, ao, bi, ri, oi, j, hlt, su, eo_n, fi_n,
            ir[3:0], 3'(st)};
  endfunction

  function automatic logic [22:0] dut_out();
    return {CO, MI, RO, II, CE, IO, AI, AO, BI, RI, OI, J, HLT, SU, EO_n, FI_n,
            IR_LOW, STEP};
  endfunction

  // Apply inputs for the current cycle and compare the full control word.
  task automatic drive(input logic [7:0] bus, input logic cf, input logic zf, input logic clr);
    BUS_IN = bus;
    CF     = cf;
    ZF     = zf;
    CLR    = clr;
    #1;
    if (m_valid) check("ctrl", 32'(dut_out()), 32'(model_out(m_ir, m_step, CF, ZF)));
  endtask

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic tick();
    logic [3:0] op;
    @(posedge CLK);
    if (CLR) begin
      m_ir    = 8'h00;
      m_step  = 0;
      m_valid = 1'b1;
    end else if (m_valid && !(m_step == 2 && m_ir[7:4] == 4'hF)) begin
      op = (m_step == 1) ? BUS_IN[7:4] : m_ir[7:4];
      if (m_step == 1) m_ir = BUS_IN;
      m_step = (m_step + 1 >= instr_len(op)) ? 0 : m_step + 1;
    end
    #1;
  endtask

  task automatic fetch(input logic [7:0] v);
    drive(8'h00, 0, 0, 0);
    tick();
    drive(v, 0, 0, 0);
    tick();
  endtask

  task automatic run_to_t0();
    for (int i = 0; i < 8 && m_step != 0; i++) begin
      drive(8'h00, 0, 0, 0);
      tick();
    end
    check("to_t0", 32'(STEP), 32'd0);
  endtask

  initial begin
    logic [7:0] bus;
    // Reset held for two edges.
    drive(8'h00, 0, 0, 1);
    tick();
    drive(8'h00, 0, 0, 1);
    tick();
    drive(8'h00, 0, 0, 0);
    check("rst_step", 32'(STEP), 32'd0);
    check("rst_co", 32'(CO), 32'd1);
    check("rst_mi", 32'(MI), 32'd1);
    check("rst_eo_n", 32'(EO_n), 32'd1);
    check("rst_fi_n", 32'(FI_n), 32'd1);
    check("rst_ir_low", 32'(IR_LOW), 32'd0);
    $display("reset done step=%0d", STEP);

    // ADD 0x2A through all five steps.
    tick();
    drive(8'h2A, 0, 0, 0);
    check("add_t1_ii", 32'({RO, II, CE}), 32'b111);
    tick();
    drive(8'h00, 0, 0, 0);
    check("add_ir_low", 32'(IR_LOW), 32'hA);
    check("add_t2_io_mi", 32'({IO, MI}), 32'b11);
    tick();
    drive(8'h00, 0, 0, 0);
    check("add_t3_ro_bi", 32'({RO, BI, STEP}), {27'd0, 2'b11, 3'd3});
    tick();
    drive(8'h00, 0, 0, 0);
    check("add_t4", 32'({AI, EO_n, FI_n, SU, STEP}), {25'd0, 4'b1000, 3'd4});
    tick();
    drive(8'h00, 0, 0, 0);
    check("add_next_step", 32'(STEP), 32'd0);
    $display("ADD 0x2A done");

    // Conditional jumps, including a flag change inside T2.
    fetch(8'h7C);
    drive(8'h00, 0, 0, 0);
    check("jc_cf0_j", 32'(J), 32'd0);
    drive(8'h00, 1, 0, 0);
    check("jc_cf1_j_io", 32'({J, IO}), 32'b11);
    tick();
    run_to_t0();
    fetch(8'h85);
    drive(8'h00, 0, 1, 0);
    check("jz_zf1_j", 32'(J), 32'd1);
    drive(8'h00, 1, 0, 0);
    check("jz_zf0_j", 32'(J), 32'd0);
    tick();
    run_to_t0();
    $display("JC 0x7C / JZ 0x85 done");

    // LDI step sequence, which depends on the shortcut option.
    for (int i = 0; i < $size(ldi_seq); i++) begin
      drive((i == 1) ? 8'h57 : 8'h00, 0, 0, 0);
      check("ldi_step", 32'(STEP), 32'(ldi_seq[i]));
      tick();
    end
    run_to_t0();
    $display("LDI 0x57 done");

    // Halt holds for 10 edges; only reset exits.
    fetch(8'hF0);
    drive(8'h00, 0, 0, 0);
    check("hlt_t2", 32'(HLT), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(8'hFF, 1, 1, 0);
      check("hlt_hold_step", 32'(STEP), 32'd2);
      check("hlt_hold_ir", 32'(IR_LOW), 32'd0);
    end
    drive(8'h00, 0, 0, 1);
    tick();
    drive(8'h00, 0, 0, 0);
    check("hlt_exit", 32'({HLT, STEP}), 32'd0);
    $display("HLT 0xF0 done");

    // Reset at the T3 edge of SUB abandons the instruction.
    fetch(8'h31);
    drive(8'h00, 0, 0, 0);
    tick();
    drive(8'h00, 0, 0, 1);
    tick();
    drive(8'h00, 0, 0, 0);
    check("midrst_step_ir", 32'({STEP, IR_LOW}), 32'd0);
    check("midrst_no_t4", 32'({SU, FI_n, EO_n}), 32'b011);
    $display("SUB 0x31 mid-op reset done");

    // Random instruction streams against the model.
    for (int n = 0; n < 3000; n++) begin
      bus = 8'($urandom);
      if (bus[7:4] == 4'hF && $urandom_range(0, 3) != 0) bus[7:4] = 4'($urandom_range(0, 14));
      drive(bus, 1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
      tick();
    end
    $display("random stream done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- CLK  input  1  the single clock; all state updates on the rising edge.
- CLR  input  1  reset; synchronous, active-high.
- BUS_IN  input  8  system bus value; sampled into IR when II=1.
- CF  input  1  carry flag from the ALU flag register.
- ZF  input  1  zero flag from the ALU flag register.
- CO, MI, RO, II, CE, IO, AI, AO, BI, RI, OI, J, HLT, SU  output  1 each  active-high control lines.
- EO_n  output  1  ALU bus output enable, active-low.
- FI_n  output  1  ALU flag-register load enable, active-low.
- IR_LOW  output  4  IR[3:0], operand nibble driven to the bus when IO=1.
- STEP  output  3  current microstep T0..T4.

Function
REQ-002 State SHALL be IR[7:0] and STEP[2:0], with OPC=IR[7:4].
REQ-003 All control outputs SHALL be combinational decodes of IR, STEP, CF and ZF, with no output registers.
REQ-004 Any control line not asserted by the current step SHALL be inactive: 0, or 1 for EO_n and FI_n.
REQ-005 In T0 the block SHALL assert CO and MI.
REQ-006 In T1 the block SHALL assert RO, II and CE, and IR SHALL load BUS_IN at the closing edge.
REQ-007 OPC 0x1 (LDA) SHALL assert IO and MI in T2, then RO and AI in T3.
REQ-008 OPC 0x2 (ADD) SHALL assert IO and MI in T2, RO and BI in T3, then AI with EO_n=0 and FI_n=0 in T4.
REQ-009 OPC 0x3 (SUB) SHALL match ADD and additionally assert SU in T4.
REQ-010 OPC 0x4 (STA) SHALL assert IO and MI in T2, then AO and RI in T3.
REQ-011 OPC 0x5 (LDI) SHALL assert IO and AI in T2.
REQ-012 OPC 0x6 (JMP) SHALL assert IO and J in T2.
REQ-013 OPC 0x7 (JC) SHALL assert IO in T2, and J only when CF=1.
REQ-014 OPC 0x8 (JZ) SHALL assert IO in T2, and J only when ZF=1.
REQ-015 OPC 0xE (OUT) SHALL assert AO and OI in T2.
REQ-016 OPC 0xF (HLT) SHALL assert HLT in T2.
REQ-017 OPC 0x0 and undefined opcodes SHALL assert nothing in T2..T4.
REQ-018 STEP SHALL advance by 1 per edge and wrap T4->T0.
REQ-019 While HLT=1, STEP and IR SHALL hold, and only CLR SHALL exit the halt.
REQ-020 CF and ZF SHALL be sampled combinationally in T2, so a flag change within T2 SHALL be reflected on J in that same cycle.

Reset
REQ-021 CLR=1 at a rising edge SHALL set IR=0x00 and STEP=0.
REQ-022 After reset the outputs SHALL show the T0 decode: CO=MI=1, all other active-high lines 0, EO_n=FI_n=1, IR_LOW=0, STEP=0.
REQ-023 CLR SHALL take priority over the halt hold and over an IR load in the same cycle.
REQ-024 A mid-instruction CLR SHALL abandon the instruction, with the next cycle at T0.
REQ-025 State SHALL be undefined until the first edge with CLR=1, and benches SHALL apply CLR for at least 1 edge.

Configuration
REQ-026 The block SHALL support the macro SEQ_SHORTCUT_EN, compiled in or out.
REQ-027 Without SEQ_SHORTCUT_EN, every instruction SHALL take 5 cycles (T0..T4), with idle steps asserting nothing.
REQ-028 With SEQ_SHORTCUT_EN, STEP SHALL return to T0 after the last active step of each instruction, and all output decodes SHALL be unchanged:
- after T3 for LDA and STA;
- after T2 for LDI, JMP, JC, JZ and OUT;
- after T1 for NOP and undefined opcodes;
- after T4 for ADD and SUB;
- HLT stays in T2 per REQ-019.

Verification
REQ-029 Reset check: CLR=1 for 2 edges, then release -> STEP=0, CO=MI=1, EO_n=FI_n=1, IR=0.
REQ-030 ADD fetch: BUS_IN=0x2A in T1 -> IR=0x2A and IR_LOW=0xA; IO+MI in T2; RO+BI in T3; AI with EO_n=0, FI_n=0, SU=0 in T4; STEP=0 next.
REQ-031 Conditional jump: IR=0x7C with CF=0 -> J=0 in T2; IR=0x7C with CF=1 -> J=1 and IO=1 in T2; IR=0x85 with ZF=1 -> J=1.
REQ-032 Halt: IR=0xF0 -> HLT=1 in T2, STEP stays 2 for 10 edges, then CLR -> STEP=0 and HLT=0.
REQ-033 Mid-op reset: CLR at the T3 edge of SUB (0x31) -> STEP=0 and IR=0x00 next cycle, with no T4 strobes (SU, FI_n=0, EO_n=0).
REQ-034 Shortcut: with SEQ_SHORTCUT_EN, LDI (0x57) -> T0,T1,T2,T0; without it -> T0..T4 then T0.
